// File: rtl/snake_pkg.sv
// Shared snake game definitions: board defaults, FSM states, direction codes, LFSR step.
package snake_pkg;

    localparam int unsigned WIDTH           = 32;
    localparam int unsigned HEIGHT          = 24;
    localparam int unsigned MAX_LEN         = 31;
    localparam int unsigned NUM_LEN         = 10;
    localparam int unsigned MAX_LEN_BIT_LEN = 5;
    localparam int unsigned LFSR_W          = 10;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        EAT,
        FOOD,
        DEAD
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Fibonacci step for x^10 + x^7 + 1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[9] ^ v[6]};
    endfunction

endpackage

// File: rtl/snake_judge_if.sv
// Bus between the movement stage (master) and the game-state keeper (slave).
interface snake_judge_if #(
    parameter int unsigned max_len         = snake_pkg::MAX_LEN,
    parameter int unsigned num_len         = snake_pkg::NUM_LEN,
    parameter int unsigned max_len_bit_len = snake_pkg::MAX_LEN_BIT_LEN
) ();

    logic                         step;
    logic [max_len*num_len-1:0]   next_pos_num;
    logic                         wall_hit;
    logic [max_len*num_len-1:0]   pos_num;
    logic [max_len_bit_len-1:0]   len;
    logic [num_len-1:0]           food_pos;
    logic [7:0]                   score;
    logic                         dead;
    logic                         busy;
    logic                         done;

    modport master (
        output step, next_pos_num, wall_hit,
        input  pos_num, len, food_pos, score, dead, busy, done
    );

    modport slave (
        input  step, next_pos_num, wall_hit,
        output pos_num, len, food_pos, score, dead, busy, done
    );

endinterface

// File: rtl/food_lfsr.sv
// 10-bit Fibonacci LFSR used to draw food candidates; steps only on advance.
module food_lfsr
    import snake_pkg::*;
#(
    parameter logic [LFSR_W-1:0] lfsr_seed = 10'h2A5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= lfsr_seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/snake_judge.sv
// Snake game-state keeper: latches moves, checks collisions, grows and places food.
// Build option: SNAKE_SELF_COLLIDE_EN adds the per-tick self-collision SCAN state.
module snake_judge
    import snake_pkg::*;
#(
    parameter int unsigned max_len         = MAX_LEN,
    parameter int unsigned num_len         = NUM_LEN,
    parameter int unsigned width           = WIDTH,
    parameter int unsigned height          = HEIGHT,
    parameter int unsigned max_len_bit_len = MAX_LEN_BIT_LEN,
    parameter int unsigned init_len        = 3,
    parameter int unsigned init_head       = 400,
    parameter int unsigned food_init       = 100,
    parameter logic [LFSR_W-1:0] lfsr_seed = 10'h2A5
) (
    input  logic          clk,
    input  logic          rst,
    snake_judge_if.slave  bus
);

    localparam int unsigned CELLS = width * height;
    localparam int unsigned LW    = max_len_bit_len;

    typedef logic [num_len-1:0] cell_t;

    state_t            state_q, state_d;
    cell_t             slot_q [max_len];
    cell_t             slot_d [max_len];
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     idx_q, idx_d;
    cell_t             food_q, food_d;
    logic [7:0]        score_q, score_d;
    logic              dead_q, dead_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_val;

    cell_t head, next_head, candidate, cmp_ref;
    logic  cmp_hit, last_idx, in_range;

    function automatic cell_t reset_slot(input int unsigned i);
        if (i < init_len) return num_len'(init_head - i);
        return num_len'(init_head - (init_len - 1));
    endfunction

    food_lfsr #(.lfsr_seed(lfsr_seed)) u_food_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    // One comparator serves both the self-collision scan and the food occupancy check
    assign head      = slot_q[0];
    assign next_head = bus.next_pos_num[num_len-1:0];
    assign candidate = num_len'(lfsr_val);
    assign cmp_ref   = (state_q == FOOD) ? candidate : head;
    assign cmp_hit   = (slot_q[idx_q] == cmp_ref);
    assign last_idx  = (idx_q == (len_q - LW'(1)));
    assign in_range  = (32'(candidate) < CELLS);

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        len_d    = len_q;
        idx_d    = idx_q;
        food_d   = food_q;
        score_d  = score_q;
        dead_d   = dead_q;
        done_d   = 1'b0;
        lfsr_adv = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.step) begin
                    if (bus.wall_hit) begin
                        dead_d  = 1'b1;
                        state_d = DEAD;
                    end else begin
                        for (int unsigned i = 0; i < max_len; i++) begin
                            slot_d[i] = bus.next_pos_num[i*num_len +: num_len];
                        end
`ifdef SNAKE_SELF_COLLIDE_EN
                        if (len_q > LW'(1)) begin
                            idx_d   = LW'(1);
                            state_d = SCAN;
                        end else begin
                            done_d  = (next_head != food_q);
                            state_d = EAT;
                        end
`else
                        done_d  = (next_head != food_q);
                        state_d = EAT;
`endif
                    end
                end
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            SCAN: begin
                if (cmp_hit) begin
                    dead_d  = 1'b1;
                    state_d = DEAD;
                end else if (last_idx) begin
                    done_d  = (head != food_q);
                    state_d = EAT;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
`endif
            // done for the no-food case was raised on entry so it is visible this cycle
            EAT: begin
                if (head == food_q) begin
                    len_d    = (len_q == LW'(max_len)) ? len_q : len_q + LW'(1);
                    score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    idx_d    = '0;
                    lfsr_adv = 1'b1;
                    state_d  = FOOD;
                end else begin
                    state_d = IDLE;
                end
            end
            FOOD: begin
                if (!in_range || cmp_hit) begin
                    lfsr_adv = 1'b1;
                    idx_d    = '0;
                end else if (last_idx) begin
                    food_d  = candidate;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            DEAD: begin
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN) || (state_d == EAT) || (state_d == FOOD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < max_len; i++) begin
                slot_q[i] <= reset_slot(i);
            end
            len_q   <= LW'(init_len);
            idx_q   <= '0;
            food_q  <= num_len'(food_init);
            score_q <= '0;
            dead_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            food_q  <= food_d;
            score_q <= score_d;
            dead_q  <= dead_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar g = 0; g < max_len; g++) begin : g_pos_out
        assign bus.pos_num[g*num_len +: num_len] = slot_q[g];
    end

    assign bus.len      = len_q;
    assign bus.food_pos = food_q;
    assign bus.score    = score_q;
    assign bus.dead     = dead_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_snake_judge.sv
// Scoreboard bench for snake_judge: a rule-level game model predicts each tick's outcome and timing.
module tb_snake_judge;
    import snake_pkg::*;

    localparam int ML    = MAX_LEN;
    localparam int NL    = NUM_LEN;
    localparam int CELLS = WIDTH * HEIGHT;
    localparam logic [9:0] SEED = 10'h2A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_judge_if bus ();
    snake_judge dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit               is_dead;
        int               cyc;
        logic [ML*NL-1:0] pos;
        int               len;
        int               score;
        int               food;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int         m_pos [ML];
    int         m_len, m_score, m_food;
    logic [9:0] m_lfsr;
    bit         m_dead;
    int         stim [ML];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic void chk_pos(string nm, logic [ML*NL-1:0] act, logic [ML*NL-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endfunction

    function automatic logic [ML*NL-1:0] pack_model();
        logic [ML*NL-1:0] v;
        for (int i = 0; i < ML; i++) v[i*NL +: NL] = NL'(m_pos[i]);
        return v;
    endfunction

    function automatic logic [ML*NL-1:0] pack_stim();
        logic [ML*NL-1:0] v;
        for (int i = 0; i < ML; i++) v[i*NL +: NL] = NL'(stim[i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ML; i++) m_pos[i] = (i < 3) ? 400 - i : 398;
        m_len = 3; m_score = 0; m_food = 100; m_lfsr = SEED; m_dead = 0;
    endfunction

    function automatic void push_exp(bit d, int c);
        exp_t e;
        e.is_dead = d; e.cyc = c; e.pos = pack_model();
        e.len = m_len; e.score = m_score; e.food = m_food;
        sb.push_back(e);
    endfunction

    // k: value of cyc just after the sampling edge; spec cycle k+n is seen here as cyc k+n-1
    function automatic void model_step(bit wall, int k);
        int l0, cost, c, hit;
        if (m_dead) return;
        if (wall) begin
            m_dead = 1;
            push_exp(1, k);
            return;
        end
        for (int i = 0; i < ML; i++) m_pos[i] = stim[i];
`ifdef SNAKE_SELF_COLLIDE_EN
        for (int j = 1; j < m_len; j++) begin
            if (m_pos[j] == m_pos[0]) begin
                m_dead = 1;
                push_exp(1, k + j);
                return;
            end
        end
        l0 = m_len;
`else
        l0 = 1;
`endif
        if (m_pos[0] != m_food) begin
            push_exp(0, k + l0 - 1);
            return;
        end
        m_len   = (m_len < ML) ? m_len + 1 : ML;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        cost = 0;
        do begin
            m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
            c = int'(m_lfsr);
            hit = -1;
            if (c >= CELLS) begin
                cost += 1;
            end else begin
                for (int s = 0; s < m_len; s++) if (hit < 0 && m_pos[s] == c) hit = s;
                cost += (hit < 0) ? m_len : hit + 1;
            end
        end while (c >= CELLS || hit >= 0);
        m_food = c;
        push_exp(0, k + l0 + cost);
    endfunction

    // Monitor: every done pulse or rising dead consumes one scoreboard entry
    bit prev_dead = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1 || (bus.dead === 1'b1 && !prev_dead)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%0d dead=%0d at cycle %0d, expected no event",
                         bus.done, bus.dead, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_dead",  int'(bus.dead), int'(e.is_dead));
                chk("event_cycle", cyc, e.cyc);
                chk_pos("event_pos", bus.pos_num, e.pos);
                chk("event_len",   int'(bus.len), e.len);
                chk("event_score", int'(bus.score), e.score);
                chk("event_food",  int'(bus.food_pos), e.food);
            end
        end
        prev_dead = (bus.dead === 1'b1);
    end

    task automatic make_shift(input int head);
        stim[0] = head;
        for (int i = 1; i < ML; i++) stim[i] = m_pos[i-1];
    endtask

    task automatic do_step(input bit wall);
        model_step(wall, cyc + 1);
        bus.next_pos_num = pack_stim();
        bus.wall_hit = wall;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        bus.wall_hit = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wait_idle: %0d events pending after %0d cycles, expected 0", sb.size(), n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic chk_outputs(input string tag);
        chk_pos({tag, "_pos"}, bus.pos_num, pack_model());
        chk({tag, "_len"},   int'(bus.len), m_len);
        chk({tag, "_food"},  int'(bus.food_pos), m_food);
        chk({tag, "_score"}, int'(bus.score), m_score);
        chk({tag, "_dead"},  int'(bus.dead), int'(m_dead));
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0;
        bus.step = 1'b0;
        bus.wall_hit = 1'b0;
        bus.next_pos_num = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_outputs("reset");

        // plain move without food
        make_shift(401);
        do_step(1'b0);
        wait_idle();

        // random mix of eating and wandering heads
        for (int t = 0; t < 60; t++) begin
            make_shift(($urandom_range(0, 1) == 1) ? m_food : int'($urandom_range(0, CELLS - 1)));
            do_step(1'b0);
            wait_idle();
            if (m_dead) begin
                do_reset();
                chk_outputs("reset_after_death");
            end
        end

        // long eating run drives len and score into saturation
        for (int t = 0; t < 260; t++) begin
            make_shift(m_food);
            do_step(1'b0);
            wait_idle();
        end

        // step (with wall_hit) while busy must be ignored
        make_shift(m_food);
        do_step(1'b0);
        chk("busy_during_tick", int'(bus.busy), 1);
        make_shift(int'($urandom_range(0, CELLS - 1)));
        bus.next_pos_num = pack_stim();
        bus.wall_hit = 1'b1;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        bus.wall_hit = 1'b0;
        wait_idle();
        chk("dead_after_busy_step", int'(bus.dead), 0);

        // reset in the middle of a food search
`ifdef SNAKE_SELF_COLLIDE_EN
        l0 = m_len;
`else
        l0 = 1;
`endif
        make_shift(m_food);
        do_step(1'b0);
        repeat (l0) @(negedge clk);
        do_reset();
        chk_outputs("reset_mid_food");

        // grow to len 5, then overlap the head with slot 2
        for (int t = 0; t < 2; t++) begin
            make_shift(m_food);
            do_step(1'b0);
            wait_idle();
        end
        chk("len_before_overlap", int'(bus.len), 5);
        stim[0] = 405; stim[1] = 406; stim[2] = 405;
        for (int i = 3; i < ML; i++) stim[i] = m_pos[i-1];
        do_step(1'b0);
        wait_idle();
        if (m_dead) do_reset();

        // wall hit, then later steps are ignored until reset
        make_shift(m_food);
        do_step(1'b1);
        wait_idle();
        for (int t = 0; t < 3; t++) begin
            make_shift(int'($urandom_range(0, CELLS - 1)));
            do_step(1'b0);
            repeat (10) @(negedge clk);
        end
        chk_outputs("dead_hold");
        do_reset();
        chk_outputs("final_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_judge.md
# snake_judge

Game-state keeper directly downstream of the snake movement stage. On each move tick it latches the shifted segment array, checks wall hit and self-collision, detects food, grows the snake and places new food with an LFSR search that rejects occupied cells. Its `pos_num` and `len` outputs feed back as the movement stage's previous-position and length inputs; `food_pos`, `dead` and `score` go to the renderer and display.

## Interface
- `max_len`, default 31: segment slots.
- `num_len`, default 10: bits per cell index (row*width+col).
- `width`, default 32: columns.
- `height`, default 24: rows.
- `max_len_bit_len`, default 5: width of `len`.
- `init_len`, default 3: length after reset, 1..max_len.
- `init_head`, default 400: head cell after reset.
- `food_init`, default 100: food cell after reset.
- `lfsr_seed`, default 10'h2A5: non-zero LFSR seed.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `step` in 1: move-tick pulse; the movement stage's result is valid this cycle.
- `next_pos_num` in max_len*num_len: shifted segment array; slot 0 is the head.
- `wall_hit` in 1: the movement stage's `should_stop`.
- `pos_num` out max_len*num_len: registered segment array.
- `len` out max_len_bit_len: current length.
- `food_pos` out num_len: food cell.
- `score` out 8: foods eaten, saturating at 255.
- `dead` out 1: sticky game-over flag.
- `busy` out 1: high when state is not IDLE or DEAD.
- `done` out 1: one-cycle pulse when a tick has been fully processed.

## Operation
- **Reset values:**
  - slot i = init_head−i for i<init_len; all higher slots = init_head−(init_len−1).
  - `len`=init_len, `food_pos`=food_init, `score`=0, LFSR=lfsr_seed.
  - `dead`=0, `busy`=0, `done`=0; state IDLE.
- **IDLE:** on `step`:
  - if `wall_hit`=1: `pos_num` unchanged, `dead`←1, go to DEAD.
  - otherwise: `pos_num`←`next_pos_num`, idx←1, go to SCAN.
  - `step` in any other state is ignored.
- **SCAN:** one compare per cycle of slot idx against slot 0, idx = 1..len−1.
  - On a match: `dead`←1, go to DEAD.
  - After the last idx: go to EAT.
  - If len=1, SCAN passes straight to EAT with no compares.
- **EAT:**
  - If head ≠ `food_pos`: pulse `done`, go to IDLE.
  - If head = `food_pos`:
    - `len`←len+1, saturating at max_len.
    - `score`←score+1, saturating at 255.
    - go to FOOD.
  - Growth needs no slot writes: the slot at index len already holds the previous tail.
- **FOOD:**
  - Each draw advances the LFSR once (x^10+x^7+1, Fibonacci form); candidate = LFSR[num_len−1:0].
  - A candidate ≥ width*height is rejected immediately and a new draw follows.
  - Otherwise the candidate is compared against slots 0..len−1 (the new len), one per cycle.
  - Any match rejects the candidate; no match: `food_pos`←candidate, pulse `done`, go to IDLE.
  - The LFSR visits every non-zero value, so the search always terminates. Cell 0 is never chosen.
- **DEAD:** absorbing state.
  - All outputs hold; `busy`=0.
  - Only `rst` leaves DEAD.
- **Reset:** `rst` in any state, including mid-SCAN or mid-FOOD, restores all reset values on the next edge. Reset has priority over `step`.

## Timing
- `step` is sampled at edge k.
- `pos_num` is updated at edge k and feeds back combinationally to the movement stage from cycle k+1.
- No-food tick: SCAN occupies len−1 cycles and EAT one cycle. `done` is high in cycle k+len; `busy` is high in cycles k+1..k+len.
- Food tick: FOOD adds 1 cycle per out-of-range draw and up to len cycles per in-range draw. `done` rises on the cycle `food_pos` updates.
- Wall hit: `dead` is high from cycle k+1; `done` does not pulse.
- Self-collision at idx j: `dead` is high from cycle k+j+1.
- The movement tick period must exceed the worst-case busy time; the system sizes it at ≥ 2048 cycles.

## Configuration
- `SNAKE_SELF_COLLIDE_EN` defined: the SCAN state is present as described above.
- Undefined: SCAN is omitted, IDLE goes directly to EAT, and self-overlap is legal.
  - No-food `done` arrives in cycle k+1.
  - Only `wall_hit` causes death.
  - FOOD's occupancy check is present in both builds.

## Structure
- Shared package `snake_pkg` holds:
  - the defaults for width, height, max_len, num_len and max_len_bit_len;
  - the state enum IDLE/SCAN/EAT/FOOD/DEAD;
  - the direction codes (00 left, 01 right, 10 up, 11 down).
- One sub-module, `food_lfsr`: a 10-bit LFSR with `clk`, `rst`, `advance` and the value output; it resets to `lfsr_seed`.
- The slot comparator and idx counter are shared between SCAN and FOOD.

## Test plan
1. Reset with defaults: `pos_num` slots 0..2 = 400, 399, 398; slots 3..30 = 398; `len`=3; `food_pos`=100; `dead`=0.
2. `step` with head 401 and no food: `pos_num`[0]=401; `done` pulses exactly 3 cycles after `step`; `len` stays 3.
3. Food at 401, `step` with head 401: `len`=4 and `score`=1. The new `food_pos` is <768, ≠0, and differs from slots 0..3.
4. `wall_hit`=1 with `step`: `dead`=1 on the next cycle; `pos_num` unchanged; later `step` pulses are ignored until `rst`.
5. Slots {405, 406, 405, …} with len=5 and `step`: `dead` set after the idx=2 compare. With `SNAKE_SELF_COLLIDE_EN` undefined, the same stimulus gives `dead`=0 and `done` at k+1.
6. A second `step` while `busy`: ignored. `rst` asserted mid-FOOD: every output returns to its reset value on the next edge.
